// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbitration path.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        SWITCH = 2'd2
    } disp_state_t;

    localparam int DISP_W = 16;

    // Segment pattern the display controller uses for a dark digit.
    localparam logic [7:0] BLANK_CODE = 8'hFF;

endpackage

// File: rtl/prio_pick.sv
// Fixed-priority picker: the lowest set request bit wins.
module prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic         valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));
    assign valid  = |req;

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit display between prioritised requesters with minimum hold,
// a one-cycle blank between owners, and optional per-owner blinking.
module display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_TICKS  = 4,
    parameter int BLINK_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      tick,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DISP_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_blink,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      grant_pulse,
    output logic [DISP_W-1:0]         disp_data,
    output logic                      disp_blank,
    output logic                      busy,
    output disp_state_t               state_dbg
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SHOW   = SHOW;
    localparam logic [1:0] ST_SWITCH = SWITCH;

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [1:0]          state;
    logic [HW-1:0]       hold_cnt;
    logic                hold_done;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [BW-1:0]       blink_cnt_nxt;
    logic                blink_phase_nxt;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                win_valid;
    logic [DISP_W-1:0]   win_data;
    logic [DISP_W-1:0]   own_data;
    logic                own_req;
    logic                own_blink;
    logic                own_wins;

    prio_pick #(.N(NUM_REQ)) u_pick (
        .req    (req),
        .onehot (win_onehot),
        .valid  (win_valid)
    );

    always_comb begin
        win_data = '0;
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) win_data = win_data | req_data[DISP_W*i +: DISP_W];
            if (grant[i])      own_data = own_data | req_data[DISP_W*i +: DISP_W];
        end
    end

    assign own_req   = |(req & grant);
    assign own_blink = |(req_blink & grant);
    assign own_wins  = win_valid && (win_onehot == grant);

    // Blink phase restarts from "visible" whenever the owner turns blinking off.
    always_comb begin
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        if (!own_blink) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_pulse <= 1'b0;
            disp_data   <= '0;
            disp_blank  <= 1'b1;
            hold_cnt    <= '0;
            hold_done   <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            grant_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_SWITCH: begin
                    if (win_valid) begin
                        state       <= ST_SHOW;
                        grant       <= win_onehot;
                        grant_pulse <= 1'b1;
                        disp_data   <= win_data;
                        disp_blank  <= 1'b0;
                        hold_cnt    <= '0;
                        hold_done   <= 1'b0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        disp_blank <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (hold_done && !own_wins) begin
                        state      <= win_valid ? ST_SWITCH : ST_IDLE;
                        grant      <= '0;
                        disp_blank <= 1'b1;
                    end else begin
                        if (own_req) disp_data <= own_data;
                        if (tick && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
                        if (tick && hold_cnt == HOLD_LAST) hold_done <= 1'b1;
                        blink_cnt   <= blink_cnt_nxt;
                        blink_phase <= blink_phase_nxt;
                        disp_blank  <= blink_phase_nxt;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    grant      <= '0;
                    disp_blank <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = disp_state_t'(state);

endmodule
